// File: rtl/bitreverse_framer_pkg.sv
// Shared FFT datapath definitions: write-side framing states and the
// bit-reversal helper used by the bit-reverse stage and its reorder buffer.
package fftpkg;

  // Widest frame exponent the helper supports.
  localparam int MAX_LGSIZE = 16;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } wstate_t;

  // Reverse the low lgsize bits of v. Upper bits of v are expected to be zero.
  function automatic logic [MAX_LGSIZE-1:0] bitrev(input logic [MAX_LGSIZE-1:0] v,
                                                   input int lgsize);
    logic [MAX_LGSIZE-1:0] rev;
    rev = {<<{v}};
    return rev >> (MAX_LGSIZE - lgsize);
  endfunction

endpackage

// File: rtl/bitreverse_framer_if.sv
// Output stream of the reorder buffer: valid/ready handshake plus frame markers.
interface bitreverse_framer_if #(
  parameter int WIDTH = 24
);
  logic               o_valid;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_out;
  logic               o_sync;
  logic               o_last;

  modport master (output o_valid, o_out, o_sync, o_last, input i_ready);
  modport slave  (input o_valid, o_out, o_sync, o_last, output i_ready);
endinterface

// File: rtl/bitreverse_framer_dpram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// No reset on storage or on the read register.
module brev_dpram #(
  parameter int AW = 6,
  parameter int DW = 48
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Stage p1: write port and registered read, read gated by the output load.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_raddr];
  end
endmodule

// File: rtl/bitreverse_framer.sv
// Reorder buffer: writes sync-framed input frames into a double-banked RAM at
// bit-reversed addresses and streams them out in natural order on a
// valid/ready port. Frames arriving with no free bank are dropped.
module bitreverse_framer
  import fftpkg::*;
#(
  parameter int LGSIZE = 5,
  parameter int WIDTH  = 24
) (
  input  logic                 i_clk,
  input  logic                 i_areset_n,
  input  logic                 i_ce,
  input  logic                 i_sync,
  input  logic [2*WIDTH-1:0]   i_in,
  bitreverse_framer_if.master  m_out,
  output logic                 o_overflow,
  output logic                 o_syncerr
);
  localparam int N = 1 << LGSIZE;
  localparam logic [LGSIZE-1:0] LAST = LGSIZE'(N - 1);

  // Write side
  wstate_t           state, state_nxt;
  logic [LGSIZE-1:0] wcnt, wcnt_nxt;
  logic              wbank, wbank_nxt;
  logic [1:0]        full;
  logic              restart, we, set_full, ovf_nxt, serr_nxt;
  logic [LGSIZE-1:0] widx, wbrev;

  // Read side
  logic              rbank;
  logic [LGSIZE-1:0] rcnt;
  logic              vld_p1, sync_p1, last_p1;
  logic [2*WIDTH-1:0] rd_data_p1;
  logic              load, rd_done;

  // A sync restarts a frame from HUNT, or mid-frame as a resynchronisation.
  assign restart = i_ce && i_sync && ((state == HUNT) || (wcnt != '0));
  assign wbrev   = LGSIZE'(bitrev(MAX_LGSIZE'(widx), LGSIZE));

  // Write FSM next state.
  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = full[wbank] ? DROP : FILL;
    end else if (i_ce && (state != HUNT) && (wcnt == LAST)) begin
      state_nxt = HUNT;
    end
  end

  // Write FSM outputs: RAM write, counter/bank updates and error pulses.
  always_comb begin
    we        = 1'b0;
    set_full  = 1'b0;
    widx      = wcnt;
    wcnt_nxt  = wcnt;
    wbank_nxt = wbank;
    ovf_nxt   = 1'b0;
    serr_nxt  = 1'b0;
    if (restart) begin
      serr_nxt = (state != HUNT);
      wcnt_nxt = LGSIZE'(1);
      widx     = '0;
      if (full[wbank]) ovf_nxt = 1'b1;
      else             we      = 1'b1;
    end else if (i_ce && (state != HUNT)) begin
      wcnt_nxt = wcnt + LGSIZE'(1);
      if (state == FILL) begin
        we = 1'b1;
        if (wcnt == LAST) begin
          set_full  = 1'b1;
          wbank_nxt = ~wbank;
        end
      end
    end
  end

  // Write FSM state, counter, bank pointer and registered error pulses.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state      <= HUNT;
      wcnt       <= '0;
      wbank      <= 1'b0;
      o_overflow <= 1'b0;
      o_syncerr  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wcnt       <= wcnt_nxt;
      wbank      <= wbank_nxt;
      o_overflow <= ovf_nxt;
      o_syncerr  <= serr_nxt;
    end
  end

  // Bank flags: writer sets its bank, reader clears its bank (never the same one).
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      full <= '0;
    end else begin
      if (set_full) full[wbank] <= 1'b1;
      if (rd_done)  full[rbank] <= 1'b0;
    end
  end

  assign load    = full[rbank] && (!vld_p1 || m_out.i_ready);
  assign rd_done = load && (rcnt == LAST);

  brev_dpram #(
    .AW (LGSIZE + 1),
    .DW (2 * WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_waddr ({wbank, wbrev}),
    .i_wdata (i_in),
    .i_re    (load),
    .i_raddr ({rbank, rcnt}),
    .o_rdata (rd_data_p1)
  );

  // Stage p1: output register control, advanced on every load.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      rcnt    <= '0;
      rbank   <= 1'b0;
      vld_p1  <= 1'b0;
      sync_p1 <= 1'b0;
      last_p1 <= 1'b0;
    end else if (load) begin
      rcnt    <= rcnt + LGSIZE'(1);
      vld_p1  <= 1'b1;
      sync_p1 <= (rcnt == '0);
      last_p1 <= (rcnt == LAST);
      if (rcnt == LAST) rbank <= ~rbank;
    end else if (m_out.i_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // The RAM read register has no reset, so the data bus is zeroed while idle.
  assign m_out.o_valid = vld_p1;
  assign m_out.o_out   = vld_p1 ? rd_data_p1 : '0;
  assign m_out.o_sync  = sync_p1;
  assign m_out.o_last  = last_p1;

endmodule

// File: tb/tb_bitreverse_framer.sv
// Scoreboard bench for bitreverse_framer with 8-sample frames.
module tb_bitreverse_framer;
  localparam int LG = 3;
  localparam int W  = 8;
  localparam int DW = 2 * W;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          sync = 1'b0;
  logic [DW-1:0] din = '0;
  logic          ovf, serr;
  logic          ready_q = 1'b1;
  logic          ready_man = 1'b1;
  logic          rand_mode = 1'b0;

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  int   ovf_cnt = 0;
  int   serr_cnt = 0;
  int   t_first = 0;
  int   t_last = 0;
  exp_t q[$];

  // Output index k of a frame carries input index brv[k].
  int brv [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  bitreverse_framer_if #(.WIDTH(W)) bus ();
  assign bus.i_ready = ready_q;

  bitreverse_framer #(.LGSIZE(LG), .WIDTH(W)) dut (
    .i_clk      (clk),
    .i_areset_n (rst_n),
    .i_ce       (ce),
    .i_sync     (sync),
    .i_in       (din),
    .m_out      (bus),
    .o_overflow (ovf),
    .o_syncerr  (serr)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Consumer ready: manual, or random with never two low cycles in a row.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) ready_q = (!ready_q) ? 1'b1 : ($urandom_range(0, 3) != 0);
    else           ready_q = ready_man;
  end

  // Pulse counters.
  initial forever begin
    @(negedge clk);
    if (ovf)  ovf_cnt++;
    if (serr) serr_cnt++;
  end

  // Monitor: pop and compare on every accepted output.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_valid && bus.i_ready) begin
        out_cnt++;
        check("out_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("out_data", 32'(bus.o_out), 32'(e.d));
          check("out_sync", 32'(bus.o_sync), 32'(e.s));
          check("out_last", 32'(bus.o_last), 32'(e.l));
          if (e.d == 16'h0010 && e.s) t_first = cyc;
          if (e.d == 16'h0027 && e.l) t_last  = cyc;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic s);
    ce = 1'b1; sync = s; din = d;
    @(posedge clk);
    #1;
    ce = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_frame(input logic [DW-1:0] base);
    for (int k = 0; k < 8; k++) q.push_back('{base + DW'(brv[k]), (k == 0), (k == 7)});
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit expect_out);
    if (expect_out) push_frame(base);
    for (int i = 0; i < 8; i++) send(base + DW'(i), (i == 0));
  endtask

  task automatic wait_q(input string name, input int le, input int max);
    int n = 0;
    while (q.size() > le && n < max) begin @(negedge clk); n++; end
    check(name, 32'(q.size() <= le), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf0, serr0, cnt0;
    // Reset state
    #12;
    check("rst_valid", 32'(bus.o_valid), 0);
    check("rst_sync",  32'(bus.o_sync), 0);
    check("rst_last",  32'(bus.o_last), 0);
    check("rst_out",   32'(bus.o_out), 0);
    check("rst_ovf",   32'(ovf), 0);
    check("rst_serr",  32'(serr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ordering and latency
    send_frame(16'h0000, 1'b1);
    @(negedge clk);
    check("t1_lat_E", 32'(bus.o_valid), 0);
    @(negedge clk);
    check("t1_lat_E1", 32'(bus.o_valid), 1);
    check("t1_first_sync", 32'(bus.o_sync), 1);
    wait_q("t1_drain", 0, 100);

    // Pre-sync samples are ignored; two frames stream back to back
    for (int i = 0; i < 5; i++) send(16'h0050 + DW'(i), 1'b0);
    send_frame(16'h0010, 1'b1);
    send_frame(16'h0020, 1'b1);
    wait_q("t2_drain", 0, 100);
    check("t2_no_bubble", 32'(t_last - t_first), 15);

    // Backpressure: A and B buffered, C dropped, D accepted after A drains
    ready_man = 1'b0;
    idle(2);
    ovf0 = ovf_cnt;
    send_frame(16'h00A0, 1'b1);
    send_frame(16'h00B0, 1'b1);
    send_frame(16'h00C0, 1'b0);
    idle(2);
    check("t3_ovf_pulse", 32'(ovf_cnt - ovf0), 1);
    @(negedge clk);
    check("t3_hold_valid", 32'(bus.o_valid), 1);
    check("t3_hold_out", 32'(bus.o_out), 16'h00A0);
    idle(3);
    @(negedge clk);
    check("t3_stable_out", 32'(bus.o_out), 16'h00A0);
    check("t3_stable_sync", 32'(bus.o_sync), 1);
    ready_man = 1'b1;
    wait_q("t3_a_drained", 8, 200);
    send_frame(16'h00D0, 1'b1);
    wait_q("t3_drain", 0, 200);
    check("t3_ovf_total", 32'(ovf_cnt - ovf0), 1);

    // Sync error at index 5
    ovf0 = ovf_cnt; serr0 = serr_cnt;
    for (int i = 0; i < 5; i++) send(16'h0030 + DW'(i), (i == 0));
    send_frame(16'h0040, 1'b1);
    idle(2);
    check("t4_syncerr", 32'(serr_cnt - serr0), 1);
    wait_q("t4_drain", 0, 100);
    check("t4_no_ovf", 32'(ovf_cnt - ovf0), 0);

    // Reset mid-output
    send_frame(16'h0060, 1'b1);
    wait_q("t5_partial", 5, 100);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(bus.o_valid), 0);
    check("t5_rst_out",   32'(bus.o_out), 0);
    check("t5_rst_sync",  32'(bus.o_sync), 0);
    check("t5_rst_last",  32'(bus.o_last), 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt0 = out_cnt;
    for (int i = 0; i < 3; i++) send(16'h0090 + DW'(i), 1'b0);
    idle(20);
    check("t5_quiet", 32'(out_cnt - cnt0), 0);
    send_frame(16'h0070, 1'b1);
    wait_q("t5_drain", 0, 100);

    // Random input gaps and ready toggling over 100 frames
    ovf0 = ovf_cnt;
    rand_mode = 1'b1;
    for (int f = 0; f < 100; f++) begin
      logic [DW-1:0] base;
      base = DW'(16'h0100 + f * 8);
      push_frame(base);
      for (int i = 0; i < 8; i++) begin
        send(base + DW'(i), (i == 0));
        idle($urandom_range(2, 4));
      end
    end
    rand_mode = 1'b0;
    wait_q("t6_drain", 0, 2000);
    check("t6_no_ovf", 32'(ovf_cnt - ovf0), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/bitreverse_framer.md
# bitreverse_framer

Input-side reorder buffer for the pipelined FFT datapath. It receives a continuous sample stream framed by a one-cycle `i_sync` on the first sample of each `1<<LGSIZE` frame, which is the protocol the bit-reverse stage emits. It writes each frame into a double-banked memory at bit-reversed addresses and reads frames out in natural address order through a valid/ready handshake. It is used wherever a bit-reversed or sync-framed stream must be handed to a consumer that can stall.

## Interface
- `LGSIZE`, 5, log2 of frame length N.
- `WIDTH`, 24, width of each real/imag component; samples are `2*WIDTH` bits.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_areset_n`  in  1  asynchronous, active-low reset.
- `i_ce`  in  1  input sample strobe. There is no input backpressure.
- `i_sync`  in  1  qualified by `i_ce`; marks sample index 0 of a frame.
- `i_in`  in  2*WIDTH  input sample.
- `o_valid`  out  1  `o_out` holds a valid sample.
- `i_ready`  in  1  consumer accepts `o_out` when `o_valid && i_ready`.
- `o_out`  out  2*WIDTH  output sample.
- `o_sync`  out  1  qualified by `o_valid`; first sample of an output frame.
- `o_last`  out  1  qualified by `o_valid`; last sample of an output frame.
- `o_overflow`  out  1  one-cycle pulse: a frame was dropped because no bank was free.
- `o_syncerr`  out  1  one-cycle pulse: `i_sync` arrived at a nonzero frame index.

## Operation
- **Memory:** 2N words, addressed `{bank, index}`. Each bank has a `full` flag. Memory contents are not reset.
- **Write FSM states:** HUNT, FILL, DROP. Write counter `wcnt` is LGSIZE bits; write bank pointer is `wbank`.
- **HUNT:** ignore `i_ce` samples without `i_sync`. On `i_ce && i_sync`:
  - if `!full[wbank]`: write the sample to `{wbank, bitrev(0)}`, set `wcnt=1`, go to FILL;
  - otherwise: pulse `o_overflow`, set `wcnt=1`, go to DROP.
- **FILL:** each `i_ce` writes `i_in` to `{wbank, bitrev(wcnt)}` and increments `wcnt`.
  - When index N-1 is written: set `full[wbank]`, toggle `wbank`, go to HUNT. A sync on the very next `i_ce` starts the next frame with no gap.
- **DROP:** each `i_ce` increments `wcnt` and writes nothing. After index N-1, go to HUNT.
- **`i_sync` with `i_ce` while in FILL or DROP and `wcnt != 0`:**
  - pulse `o_syncerr`;
  - discard the partial frame (bank not marked full);
  - treat the sample exactly as HUNT would, i.e. a restart at index 0.
- **Read side:** read counter `rcnt` and read bank pointer `rbank`. The output register loads when `full[rbank] && (!o_valid || i_ready)`.
  - Load: `o_out <= mem[{rbank, rcnt}]`, `o_sync <= (rcnt==0)`, `o_last <= (rcnt==N-1)`, `o_valid <= 1`, then increment `rcnt`.
  - Loading index N-1 clears `full[rbank]` and toggles `rbank`.
  - If `o_valid && i_ready` and nothing loads, `o_valid <= 0`.
- **Flag ownership:** the writer only sets `full[wbank]`; the reader only clears `full[rbank]`. Simultaneous set and clear always target different banks.
- **Resulting order:** output sample k of a frame equals input sample `bitrev(k)`.

## Timing
- **Reset:** asynchronous and immediate. `o_valid`, `o_sync`, `o_last`, `o_overflow`, `o_syncerr`, `o_out` = 0; both `full` = 0; `wbank=rbank=0`; `wcnt=rcnt=0`; FSM in HUNT.
- **After reset release:** no sample is written until an `i_sync`.
- **Latency:** let E be the edge that writes index N-1. `full` is visible after E. The first `o_valid` (with `o_sync`) rises after edge E+1.
- **Throughput:** one sample per cycle while `i_ready` is held high. This sustains `i_ce=1` indefinitely.
- **Freed bank:** a bank freed by the reader at edge R can accept a sync beginning at edge R+1 or later. A sync at edge R itself still sees the bank full and drops the frame.
- **Flag timing:** `o_overflow` and `o_syncerr` are registered and high for exactly one cycle, following the triggering edge.
- **Output stability:** `o_out`, `o_sync` and `o_last` are held stable while `o_valid && !i_ready`.

## Structure
- Shared package (`fftpkg`) holds:
  - the write FSM state enum (HUNT/FILL/DROP);
  - a `bitrev(LGSIZE)` function, also used by the existing bit-reverse stage and its testbench model.
- One sub-module, `brev_dpram`: 2N×(2*WIDTH) simple dual-port RAM with registered read and no reset. The output register enable acts as its read enable.
- Everything else stays in the top module.

## Test plan
- **Basic ordering:** LGSIZE=3, one frame 0..7 with `i_sync` on 0, `i_ready=1` → outputs 0,4,2,6,1,5,3,7; `o_sync` on 0, `o_last` on 7; first `o_valid` after edge E+1.
- **Pre-sync data and streaming:** 5 samples without sync, then continuous frames 10..17, 20..27 → pre-sync samples never appear; the two frames are output back-to-back with no bubble.
- **Backpressure and drop:** `i_ready=0` while frames A, B, C stream, then `i_ready=1` → A and B are output intact; C is dropped with exactly one `o_overflow` pulse at C's sync; frame D, synced after A drains, is output.
- **Sync error:** `i_sync` at index 5 of a frame → one `o_syncerr` pulse; the partial frame is never output; the new frame starting at that sample is output correctly.
- **Reset mid-frame:** `i_areset_n` low mid-output → all outputs 0 in the same cycle; after release, nothing is output until a new sync-aligned frame completes.
- **`i_ce` gaps:** random `i_ce` gaps and random `i_ready` toggling over 100 frames → the scoreboard matches a bit-reverse model; no `o_overflow` while the consumer duty cycle is ≥ the input duty cycle.
